// File: rtl/arm_seq_pkg.sv
// Shared constants, state encoding and level quantizer for the arm level sequencer.
// Fault-latch option is selected with ARM_SEQ_FAULT_LATCH_EN.
package arm_seq_pkg;

    localparam logic [2:0] LVL_MIN  = 3'd0;
    localparam logic [2:0] LVL_ZERO = 3'd2;
    localparam logic [2:0] LVL_MAX  = 3'd4;

    localparam int GATE_W = 4;
    localparam logic [GATE_W-1:0] GATES_OFF = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    // Round ref*4/256 to nearest level; 11 bits holds the 1148 maximum.
    function automatic logic [2:0] quantize(input logic [7:0] r);
        logic [10:0] s;
        s = {1'b0, r, 2'b00} + 11'd128;
        return s[10:8];
    endfunction

endpackage

// File: rtl/arm_gate_deadtime.sv
// Dead-time sequencer: blanks turning-on gate bits for DEAD clocks before
// applying a new switch pattern.
module arm_gate_deadtime
    import arm_seq_pkg::*;
#(
    parameter int DEAD = 50
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_kill,
    input  logic [GATE_W-1:0] i_fo,
    output logic [GATE_W-1:0] o_gate,
    output logic              o_busy
);

    localparam int CW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEAD - 1);

    logic [1:0]        r_state;
    logic [GATE_W-1:0] r_gate;
    logic [GATE_W-1:0] r_tgt;
    logic [CW-1:0]     r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gate  <= GATES_OFF;
            r_tgt   <= GATES_OFF;
            r_cnt   <= '0;
        end else if (!i_enable || i_kill) begin
            r_state <= ST_IDLE;
            r_gate  <= GATES_OFF;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_fo != r_gate) begin
                        r_tgt   <= i_fo;
                        r_gate  <= r_gate & i_fo;
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    // A new pattern mid-blank restarts the full dead time.
                    if (i_fo != r_tgt) begin
                        r_tgt  <= i_fo;
                        r_gate <= r_gate & i_fo;
                        r_cnt  <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_gate  <= r_tgt;
                        r_state <= ST_APPLY;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_APPLY: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_gate = r_gate;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/arm_level_sequencer.sv
// Period strobe, slew-limited level and gate sequencing for one converter arm.
// Define ARM_SEQ_FAULT_LATCH_EN to enable the latched external trip.
module arm_level_sequencer
    import arm_seq_pkg::*;
#(
    parameter int PERIOD   = 1000,
    parameter int DEAD     = 50,
    parameter int MAX_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [7:0]        i_ref,
    input  logic [GATE_W-1:0] i_fo_in,
    input  logic              i_fault,
    output logic              o_period_flag,
    output logic [2:0]        o_vc_level,
    output logic [GATE_W-1:0] o_gate,
    output logic              o_busy,
    output logic              o_fault_latched
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0] r_count;
    logic          r_flag;
    logic [2:0]    r_vc;
    logic          w_last;
    logic          w_upd;
    logic          w_trip;
    logic [2:0]    w_tgt;
    logic [2:0]    w_lvl_next;
    int            w_diff;
    int            w_step;

`ifdef ARM_SEQ_FAULT_LATCH_EN
    logic r_fault;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_fault <= 1'b0;
        else       r_fault <= r_fault | i_fault;
    end

    assign w_trip          = i_fault | r_fault;
    assign o_fault_latched = r_fault;
`else
    logic w_unused_fault;
    assign w_unused_fault  = i_fault;
    assign w_trip          = 1'b0;
    assign o_fault_latched = 1'b0;
`endif

    assign w_last = (r_count == PW'(PERIOD - 1));
    assign w_upd  = (r_count == PW'(PERIOD - 2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_count <= '0;
        else if (!i_enable) r_count <= '0;
        else if (w_last)    r_count <= '0;
        else                r_count <= r_count + PW'(1);
    end

    always_comb begin
        w_tgt  = quantize(i_ref);
        w_diff = int'(w_tgt) - int'(r_vc);
        if (w_diff > MAX_STEP)       w_step = int'(r_vc) + MAX_STEP;
        else if (w_diff < -MAX_STEP) w_step = int'(r_vc) - MAX_STEP;
        else                         w_step = int'(w_tgt);
        if (w_step < int'(LVL_MIN)) w_step = int'(LVL_MIN);
        if (w_step > int'(LVL_MAX)) w_step = int'(LVL_MAX);
        w_lvl_next = 3'(w_step);
    end

    // Level settles one clock ahead of the strobe the balancer samples on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vc   <= LVL_ZERO;
            r_flag <= 1'b0;
        end else begin
            r_flag <= i_enable && w_last && !w_trip;
            if (w_trip)                r_vc <= LVL_ZERO;
            else if (i_enable && w_upd) r_vc <= w_lvl_next;
        end
    end

    arm_gate_deadtime #(
        .DEAD (DEAD)
    ) u_deadtime (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_kill   (w_trip),
        .i_fo     (i_fo_in),
        .o_gate   (o_gate),
        .o_busy   (o_busy)
    );

    assign o_period_flag = r_flag;
    assign o_vc_level    = r_vc;

endmodule
